truncator_16in_12out: RTL and testbench

TRUNCATOR_16IN_12OUT -- requirements
Module: truncator_16in_12out

---
 rtl/truncator_16in_12out.sv | 124 ++++++++++++
 tb/tb_truncator_16in_12out.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/truncator_16in_12out.sv
// Narrows a 16-bit input word to 12-bit output beats. A word with a nonzero upper
// nibble is either split into a low beat and a high beat or clamped to 12'hFFF.
module truncator_16in_12out #(
    parameter bit SATURATE = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] bit16_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] bit12_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        overflow,
    output logic [7:0]  ovf_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  nibble_q, nibble_d;
    logic [11:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        upper_nz;

    assign upper_nz = |bit16_in[15:12];

    always_comb begin
        state_d  = state_q;
        nibble_d = nibble_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        in_ready = (state_q == IDLE);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Only the upper nibble is needed after capture; the low beat is
                    // loaded straight into the output register.
                    nibble_d = bit16_in[15:12];
                    state_d  = LO;
                    valid_d  = 1'b1;
                    if (!upper_nz) begin
                        data_d = bit16_in[11:0];
                        last_d = 1'b1;
                        ovf_d  = 1'b0;
                    end else if (SATURATE) begin
                        data_d = 12'hFFF;
                        last_d = 1'b1;
                        ovf_d  = 1'b1;
                    end else begin
                        data_d = bit16_in[11:0];
                        last_d = 1'b0;
                        ovf_d  = 1'b1;
                    end
                    if (upper_nz && cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            LO: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        state_d = HI;
                        data_d  = {8'b0, nibble_q};
                        last_d  = 1'b1;
                        ovf_d   = 1'b1;
                    end
                end
            end
            HI: begin
                if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            nibble_q <= 4'h0;
            data_q   <= 12'h000;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            nibble_q <= nibble_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bit12_out = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign overflow  = ovf_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_truncator_16in_12out.sv
// Drives a split-mode and a saturate-mode instance with randomized words and stalls,
// comparing every presented beat against a word-level reference model.
module tb_truncator_16in_12out;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [15:0] bit16_in  [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [11:0] bit12_out [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        out_last  [2];
    logic        overflow  [2];
    logic [7:0]  ovf_count [2];

    int total = 0;
    int bad   = 0;
    int mdl_cnt [2];

    truncator_16in_12out #(.SATURATE(1'b0)) dut_split (
        .clk(clk), .reset_n(reset_n), .bit16_in(bit16_in[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .bit12_out(bit12_out[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_last(out_last[0]), .overflow(overflow[0]),
        .ovf_count(ovf_count[0])
    );

    truncator_16in_12out #(.SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .bit16_in(bit16_in[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .bit12_out(bit12_out[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_last(out_last[1]), .overflow(overflow[1]),
        .ovf_count(ovf_count[1])
    );

    // {data, last, overflow}
    typedef logic [13:0] beat_t;

    // Sends one word on instance s (s==1 saturates) and drains its beats. The first
    // 'hold' presented cycles are stalled, then out_ready is low with stall_pct chance.
    task automatic run_word(input int s, input logic [15:0] w, input int hold,
                            input int stall_pct, input bit noise);
        beat_t exp[$];
        beat_t got;
        int    cyc;
        int    i;
        if (w < 16'h1000) begin
            exp.push_back({w[11:0], 2'b10});
        end else if (s == 1) begin
            exp.push_back({12'hFFF, 2'b11});
        end else begin
            exp.push_back({12'(w % 16'd4096), 2'b01});
            exp.push_back({12'(w / 16'd4096), 2'b11});
        end
        cyc = 0;
        @(negedge clk);
        bit16_in[s]  = w;
        in_valid[s]  = 1'b1;
        out_ready[s] = 1'b0;
        while (!in_ready[s] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!in_ready[s]) begin
            bad++;
            $display("FAIL accept_wait s=%0d: in_ready=%b want 1", s, in_ready[s]);
            in_valid[s] = 1'b0;
            return;
        end
        if (w[15:12] != 4'h0 && mdl_cnt[s] < 255) mdl_cnt[s]++;
        @(negedge clk);
        in_valid[s] = noise ? 1'($urandom_range(1)) : 1'b0;
        bit16_in[s] = 16'($urandom);
        total++;
        if (out_valid[s] !== 1'b1 || in_ready[s] !== 1'b0) begin
            bad++;
            $display("FAIL latency s=%0d: out_valid=%b in_ready=%b want 1 0",
                     s, out_valid[s], in_ready[s]);
        end
        i = 0;
        while (exp.size() > 0 && cyc < 400) begin
            got = {bit12_out[s], out_last[s], overflow[s]};
            total++;
            if (out_valid[s] !== 1'b1 || got !== exp[0] || in_ready[s] !== 1'b0) begin
                bad++;
                $display("FAIL beat s=%0d w=%h: valid=%b rdy=%b beat=%h want valid=1 rdy=0 %h",
                         s, w, out_valid[s], in_ready[s], got, exp[0]);
                break;
            end
            out_ready[s] = (i >= hold) && ($urandom_range(99) >= stall_pct);
            if (out_ready[s]) void'(exp.pop_front());
            @(negedge clk);
            cyc++;
            i++;
            if (exp.size() > 0) begin
                in_valid[s] = noise ? 1'($urandom_range(1)) : 1'b0;
                bit16_in[s] = 16'($urandom);
            end
        end
        in_valid[s]  = 1'b0;
        out_ready[s] = 1'b0;
        total++;
        if (exp.size() != 0 || out_valid[s] !== 1'b0 || in_ready[s] !== 1'b1) begin
            bad++;
            $display("FAIL word_end s=%0d w=%h: left=%0d valid=%b rdy=%b want 0 0 1",
                     s, w, exp.size(), out_valid[s], in_ready[s]);
        end
        total++;
        if (ovf_count[s] !== 8'(mdl_cnt[s])) begin
            bad++;
            $display("FAIL ovf_count s=%0d: got %0d want %0d", s, ovf_count[s], mdl_cnt[s]);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            total++;
            if (out_valid[s] !== 1'b0 || out_last[s] !== 1'b0 || overflow[s] !== 1'b0 ||
                bit12_out[s] !== 12'h000 || ovf_count[s] !== 8'h00) begin
                bad++;
                $display("FAIL reset_state s=%0d: v=%b l=%b o=%b d=%h c=%h want all 0",
                         s, out_valid[s], out_last[s], overflow[s], bit12_out[s],
                         ovf_count[s]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (in_ready[s] !== 1'b1) begin
                bad++;
                $display("FAIL ready_after_reset s=%0d: got %b want 1", s, in_ready[s]);
            end
        end
    endtask

    task automatic test_directed();
        run_word(0, 16'h0003, 0, 0, 1'b0);
        run_word(0, 16'hA01B, 0, 0, 1'b0);
        run_word(1, 16'h1FFF, 0, 0, 1'b0);
        run_word(1, 16'h0FFF, 0, 0, 1'b0);
        run_word(0, 16'h0FFF, 0, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_word(0, 16'hA01B, 5, 0, 1'b1);
        run_word(1, 16'hA01B, 5, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int n = 0; n < 60; n++) begin
            w = 16'($urandom);
            if ($urandom_range(1) == 0) w[15:12] = 4'h0;
            run_word(n % 2, w, 0, 40, 1'b1);
        end
    endtask

    task automatic test_ovf_saturation();
        for (int n = 0; n < 260; n++) run_word(0, 16'hF000, 0, 0, 1'b0);
        total++;
        if (ovf_count[0] !== 8'hFF) begin
            bad++;
            $display("FAIL ovf_hold: got %h want ff", ovf_count[0]);
        end
    endtask

    task automatic test_reset_mid_word();
        @(negedge clk);
        bit16_in[0] = 16'hA01B;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        total++;
        if (out_valid[0] !== 1'b1 || bit12_out[0] !== 12'h00A) begin
            bad++;
            $display("FAIL hi_beat: valid=%b data=%h want 1 00a", out_valid[0], bit12_out[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        mdl_cnt[0] = 0;
        mdl_cnt[1] = 0;
        total++;
        if (out_valid[0] !== 1'b0 || ovf_count[0] !== 8'h00 || ovf_count[1] !== 8'h00 ||
            in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: valid=%b cnt=%h/%h rdy=%b want 0 00/00 1",
                     out_valid[0], ovf_count[0], ovf_count[1], in_ready[0]);
        end
        @(negedge clk);
        reset_n      = 1'b1;
        out_ready[0] = 1'b1;
        total++;
        if (in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_mid_reset: got %b want 1", in_ready[0]);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (out_valid[0] !== 1'b0) begin
                bad++;
                $display("FAIL stale_beat cycle %0d: out_valid=%b want 0", k, out_valid[0]);
            end
        end
        out_ready[0] = 1'b0;
        run_word(0, 16'h2345, 0, 0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            bit16_in[s]  = 16'h0000;
            in_valid[s]  = 1'b0;
            out_ready[s] = 1'b0;
            mdl_cnt[s]   = 0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_ovf_saturation();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
